hdmi_rx_timing_detect: RTL and testbench
========================================

# hdmi_rx_timing_detect

Receive-side video timing decoder for the ADV7611 parallel output bus (LLC domain). It samples HS/VS/DE/D and measures line and frame geometry: h_total, h_active, v_total and v_active. It declares lock after consecutive identical frames and emits a registered pixel stream with x/y coordinates and start-of-frame/end-of-line markers. It sits between the HDMI-RX pins and the pass-through/BSOD frame logic, mirroring the TX video generator.

## Interface
- CNT_W, 12, width of all position and measurement counters (max 4095).
- LOCK_FRAMES, 3, number of consecutive matching frames required to assert `locked` (1..15).
- clk  in  1  pixel clock (ADV7611 LLC); the only clock.
- reset  in  1  asynchronous, active-high reset.
- vid_hs, vid_vs, vid_de  in  1 each  raw sync and data-enable from the receiver.
- vid_d  in  24  raw pixel data.
- pix_d  out  24  registered pixel data.
- pix_valid  out  1  pixel qualifier (delayed DE).
- pix_x, pix_y  out  CNT_W each  coordinates of the current pix_d.
- sof  out  1  one-cycle pulse with the first valid pixel of a frame.
- eol  out  1  one-cycle pulse with the last valid pixel of a line.
- h_total, h_active, v_total, v_active  out  CNT_W each  last latched frame measurement.
- locked  out  1  measurements stable.
- hs_pol, vs_pol  out  1 each  detected polarity (1 = active-low); tied 0 when the polarity feature is compiled out.

## Operation
- Stage 1: register all vid_* inputs. Stage 2: detect edges (registered value vs previous) and update counters; pix_* come out of the stage-2 register.
- Edge events use the active (leading) edge of each sync pulse after polarity correction.
- hcnt: increments every cycle and clears on HS leading edge. On that edge, latch hcnt+1 into line_total.
- decnt: increments while DE is high. On the DE falling edge, latch decnt into line_active and increment vline.
- lcnt: increments on each HS leading edge.
- On the VS leading edge:
  - Publish h_total = line_total, h_active = line_active, v_total = lcnt, v_active = vline.
  - Clear lcnt and vline.
  - Run the lock FSM.
  - The first VS edge after reset only arms measurement; nothing is published.
- All counters saturate at 2^CNT_W-1 and never wrap. A saturated value in any measurement marks that frame invalid.
- Lock FSM:
  - States: IDLE (waiting for arm), MEASURE (first frame published), TRACK.
  - In TRACK, a frame whose four values equal the previous frame's, with none saturated, increments match_cnt (saturating at LOCK_FRAMES).
  - Any mismatch or invalid frame clears match_cnt and locked.
  - locked = (match_cnt == LOCK_FRAMES).
- Pixel path:
  - pix_x counts DE-high cycles and returns to 0 after the DE falling edge.
  - pix_y increments after each DE falling edge and clears on VS.
  - sof fires when pix_valid, pix_x == 0 and pix_y == 0.
  - eol fires on the last DE-high cycle (input DE falling seen one stage early).
- A simultaneous HS and VS edge is processed as HS first: the line counts, then the frame latches.

## Timing
- Latency: vid_* sampled on clock edge N appear on pix_* after edge N+2.
- Measurements and locked update on edge N+2 after the VS leading edge is sampled at edge N; they hold until the next VS.
- Reset is asynchronous and active-high; every output goes to 0 immediately (locked = 0, hs_pol = vs_pol = 0). The FSM returns to IDLE.
- Reset mid-frame discards the partial frame. The first publish occurs at the second VS edge after release.
- sof and eol are exactly one cycle wide and coincident with pix_valid = 1.

## Configuration
- RX_TIMING_POL_AUTO_EN defined:
  - Per HS period, count high and low cycles; if high > low, set hs_pol = 1 and invert HS internally.
  - Do the same per VS period for vs_pol.
  - A polarity flip clears locked.
- Not defined: sync is assumed active-high, no inversion logic is built, and hs_pol = vs_pol = 0 constant.

## Test plan
- Synthetic mode, h_total 100, h_active 80, v_total 30, v_active 24, LOCK_FRAMES = 3, 6 frames:
  - Measurements read 100/80/30/24 after the 2nd VS edge.
  - locked rises 2 cycles after the 5th VS edge and stays high.
- After lock, change one line's HS period to 101 cycles: locked falls at the next VS publish, then re-asserts after 3 further matching frames.
- Pixel markers, same mode:
  - First DE cycle after VS gives sof = 1, pix_x = 0, pix_y = 0, with pix_d equal to the input 2 cycles earlier.
  - Last pixel of a line gives eol = 1 and pix_x = 79.
  - Last active line gives pix_y = 23.
- Hold HS inactive for 5000 cycles with CNT_W = 12: hcnt saturates at 4095, h_total publishes 4095, and locked stays 0.
- Assert reset mid-frame while locked: all outputs go to 0 without a clock. After release, publishing resumes at the 2nd VS edge.
- With RX_TIMING_POL_AUTO_EN and active-low HS/VS, same geometry: hs_pol = vs_pol = 1, measurements 100/80/30/24, and locked achieved.

Source files
------------

// File: rtl/hdmi_rx_timing_detect.sv
// rtl/hdmi_rx_timing_detect.sv - ADV7611 LLC-domain timing decoder: geometry measurement, lock and pixel stream
// Sync polarity auto-detection is built only when RX_TIMING_POL_AUTO_EN is defined.
module hdmi_rx_timing_detect #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vid_hs,
  input  logic             vid_vs,
  input  logic             vid_de,
  input  logic [23:0]      vid_d,
  output logic [23:0]      pix_d,
  output logic             pix_valid,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             sof,
  output logic             eol,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             hs_pol,
  output logic             vs_pol
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_TRACK
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // stage 1: raw input capture
  logic        s1_hs, s1_vs, s1_de;
  logic [23:0] s1_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_de <= 1'b0;
      s1_d  <= '0;
    end else begin
      s1_hs <= vid_hs;
      s1_vs <= vid_vs;
      s1_de <= vid_de;
      s1_d  <= vid_d;
    end
  end

  logic hs_pol_r, vs_pol_r, pol_flip;

`ifdef RX_TIMING_POL_AUTO_EN
  logic             s1_hs_q, s1_vs_q;
  logic [CNT_W-1:0] hs_hi, hs_lo, vs_hi, vs_lo;
  logic             hs_rise, vs_rise, hs_pol_new, vs_pol_new;

  // Raw rising edges delimit the periods; VS high/low time is counted in lines.
  assign hs_rise    = s1_hs & ~s1_hs_q;
  assign vs_rise    = s1_vs & ~s1_vs_q;
  assign hs_pol_new = (hs_hi > hs_lo);
  assign vs_pol_new = (vs_hi > vs_lo);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      hs_hi    <= '0;
      hs_lo    <= '0;
      vs_hi    <= '0;
      vs_lo    <= '0;
      hs_pol_r <= 1'b0;
      vs_pol_r <= 1'b0;
      pol_flip <= 1'b0;
    end else begin
      s1_hs_q  <= s1_hs;
      s1_vs_q  <= s1_vs;
      pol_flip <= (hs_rise && (hs_pol_new != hs_pol_r)) ||
                  (vs_rise && (vs_pol_new != vs_pol_r));
      if (hs_rise) begin
        hs_pol_r <= hs_pol_new;
        hs_hi    <= CNT_ONE;
        hs_lo    <= '0;
      end else if (s1_hs) begin
        hs_hi <= sat_inc(hs_hi);
      end else begin
        hs_lo <= sat_inc(hs_lo);
      end
      if (vs_rise) begin
        vs_pol_r <= vs_pol_new;
        vs_hi    <= '0;
        vs_lo    <= '0;
      end else if (hs_rise) begin
        if (s1_vs) vs_hi <= sat_inc(vs_hi);
        else       vs_lo <= sat_inc(vs_lo);
      end
    end
  end
`else
  assign hs_pol_r = 1'b0;
  assign vs_pol_r = 1'b0;
  assign pol_flip = 1'b0;
`endif

  assign hs_pol = hs_pol_r;
  assign vs_pol = vs_pol_r;

  // stage 2: polarity-corrected current (c_*) and previous (p_*) samples
  logic        c_hs, c_vs, c_de, p_hs, p_vs, p_de;
  logic [23:0] c_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_hs <= 1'b0;
      c_vs <= 1'b0;
      c_de <= 1'b0;
      c_d  <= '0;
      p_hs <= 1'b0;
      p_vs <= 1'b0;
      p_de <= 1'b0;
    end else begin
      c_hs <= s1_hs ^ hs_pol_r;
      c_vs <= s1_vs ^ vs_pol_r;
      c_de <= s1_de;
      c_d  <= s1_d;
      p_hs <= c_hs;
      p_vs <= c_vs;
      p_de <= c_de;
    end
  end

  logic hs_edge, vs_edge, de_fall;
  assign hs_edge = c_hs & ~p_hs;
  assign vs_edge = c_vs & ~p_vs;
  assign de_fall = p_de & ~c_de;

  logic [CNT_W-1:0] hcnt, line_total, decnt, line_active, lcnt, vline;
  logic [CNT_W-1:0] hcnt_nxt, line_total_nxt, decnt_nxt, line_active_nxt;
  logic [CNT_W-1:0] lcnt_cnt, lcnt_nxt, vline_cnt, vline_nxt;

  // *_cnt include this cycle's HS/DE event so a coincident VS latches it (HS before VS).
  always_comb begin
    hcnt_nxt        = hs_edge ? '0 : sat_inc(hcnt);
    line_total_nxt  = hs_edge ? sat_inc(hcnt) : line_total;
    decnt_nxt       = c_de ? sat_inc(decnt) : '0;
    line_active_nxt = de_fall ? decnt : line_active;
    lcnt_cnt        = hs_edge ? sat_inc(lcnt) : lcnt;
    lcnt_nxt        = vs_edge ? '0 : lcnt_cnt;
    vline_cnt       = de_fall ? sat_inc(vline) : vline;
    vline_nxt       = vs_edge ? '0 : vline_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt        <= '0;
      line_total  <= '0;
      decnt       <= '0;
      line_active <= '0;
      lcnt        <= '0;
      vline       <= '0;
    end else begin
      hcnt        <= hcnt_nxt;
      line_total  <= line_total_nxt;
      decnt       <= decnt_nxt;
      line_active <= line_active_nxt;
      lcnt        <= lcnt_nxt;
      vline       <= vline_nxt;
    end
  end

  state_t     state, state_nxt;
  logic       publish, compare;
  logic [3:0] match_cnt, match_nxt;
  logic       frame_sat, frame_same;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    compare   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vs_edge) state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (vs_edge) begin
          publish   = 1'b1;
          state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (vs_edge) begin
          publish = 1'b1;
          compare = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign frame_sat  = (line_total_nxt == CNT_MAX) || (line_active_nxt == CNT_MAX) ||
                      (lcnt_cnt == CNT_MAX) || (vline_cnt == CNT_MAX);
  assign frame_same = (line_total_nxt == h_total) && (line_active_nxt == h_active) &&
                      (lcnt_cnt == v_total) && (vline_cnt == v_active);

  always_comb begin
    match_nxt = match_cnt;
    if (pol_flip) begin
      match_nxt = '0;
    end else if (compare) begin
      if (frame_same && !frame_sat)
        match_nxt = (match_cnt == LOCK_N) ? match_cnt : match_cnt + 4'd1;
      else
        match_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_total   <= '0;
      h_active  <= '0;
      v_total   <= '0;
      v_active  <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
    end else begin
      if (publish) begin
        h_total  <= line_total_nxt;
        h_active <= line_active_nxt;
        v_total  <= lcnt_cnt;
        v_active <= vline_cnt;
      end
      match_cnt <= match_nxt;
      locked    <= (match_nxt == LOCK_N);
    end
  end

  // eol looks one stage ahead: stage 1 already shows DE gone low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_d     <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else begin
      pix_d     <= c_d;
      pix_valid <= c_de;
      pix_x     <= c_de ? decnt : '0;
      pix_y     <= vline;
      sof       <= c_de && (decnt == '0) && (vline == '0);
      eol       <= c_de && !s1_de;
    end
  end

endmodule

// File: tb/tb_hdmi_rx_timing_detect.sv
// tb/tb_hdmi_rx_timing_detect.sv - directed bench: 100x30 mode with 80x24 active, lock, markers, saturation, reset
module tb_hdmi_rx_timing_detect;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vid_hs = 1'b0, vid_vs = 1'b0, vid_de = 1'b0;
  logic [23:0] vid_d = '0;
  logic [23:0] pix_d;
  logic        pix_valid, sof, eol, locked, hs_pol, vs_pol;
  logic [11:0] pix_x, pix_y, h_total, h_active, v_total, v_active;

  hdmi_rx_timing_detect dut (
    .clk       (clk),
    .reset     (reset),
    .vid_hs    (vid_hs),
    .vid_vs    (vid_vs),
    .vid_de    (vid_de),
    .vid_d     (vid_d),
    .pix_d     (pix_d),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .sof       (sof),
    .eol       (eol),
    .h_total   (h_total),
    .h_active  (h_active),
    .v_total   (v_total),
    .v_active  (v_active),
    .locked    (locked),
    .hs_pol    (hs_pol),
    .vs_pol    (vs_pol)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic        de;
    logic        sof;
    logic        eol;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] d;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   frame_no = 0;
  exp_t h0 = '0, h1 = '0;
  logic lk_at1, lk_at2;

  task automatic expect_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Outputs seen after a tick belong to the inputs driven two ticks earlier.
  task automatic tick(input logic hs, input logic vs, input logic de, input logic [23:0] d,
                      input logic chk, input int x, input int y);
    exp_t cur;
    vid_hs = hs;
    vid_vs = vs;
    vid_de = de;
    vid_d  = d;
    @(posedge clk);
    #1;
    if (h1.chk) begin
      expect_eq("pix_ctl", 64'({pix_valid, sof, eol, pix_d}), 64'({h1.de, h1.sof, h1.eol, h1.d}));
      if (h1.de) expect_eq("pix_xy", 64'({pix_x, pix_y}), 64'({h1.x, h1.y}));
    end
    cur.chk = chk;
    cur.de  = de;
    cur.sof = de && (x == 0) && (y == 0);
    cur.eol = de && (x == 79);
    cur.x   = 12'(x);
    cur.y   = 12'(y);
    cur.d   = d;
    h1 = h0;
    h0 = cur;
  endtask

  task automatic send_frame(input int last_len, input logic pol_low, input logic chk, input int n_lines);
    for (int ln = 0; ln < n_lines; ln++) begin
      int len;
      len = (ln == 29) ? last_len : 100;
      for (int cy = 0; cy < len; cy++) begin
        logic a_hs, a_vs, a_de;
        a_hs = (cy < 10);
        a_vs = (ln < 3);
        a_de = (ln >= 3) && (ln < 27) && (cy >= 20) && (cy < 100);
        tick(a_hs ^ pol_low, a_vs ^ pol_low, a_de, {8'(frame_no), 8'(ln), 8'(cy)}, chk, cy - 20, ln - 3);
        if (ln == 0 && cy == 1) lk_at1 = locked;
        if (ln == 0 && cy == 2) lk_at2 = locked;
      end
    end
    frame_no++;
  endtask

  task automatic check_zero(input string tag);
    expect_eq({tag, "_flags"}, 64'({pix_valid, sof, eol, locked, hs_pol, vs_pol}), 64'd0);
    expect_eq({tag, "_meas"}, 64'({h_total, h_active, v_total, v_active}), 64'd0);
    expect_eq({tag, "_pix"}, 64'({pix_x, pix_y, pix_d}), 64'd0);
  endtask

  task automatic do_reset();
    vid_hs = 1'b0; vid_vs = 1'b0; vid_de = 1'b0; vid_d = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    h0 = '0;
    h1 = '0;
  endtask

  localparam logic [47:0] MEAS_OK = {12'd100, 12'd80, 12'd30, 12'd24};

  initial begin
    #1 reset = 1'b1;
    #1 check_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    send_frame(100, 1'b0, 1'b0, 30);
    expect_eq("no_publish_vs1", 64'(h_total), 64'd0);
    send_frame(100, 1'b0, 1'b0, 30);
    expect_eq("meas_vs2", 64'({h_total, h_active, v_total, v_active}), 64'(MEAS_OK));
    send_frame(100, 1'b0, 1'b1, 30);
    send_frame(100, 1'b0, 1'b0, 30);
    expect_eq("unlocked_vs4", 64'(locked), 64'd0);
    send_frame(100, 1'b0, 1'b0, 30);
    expect_eq("lock_vs5_plus1", 64'(lk_at1), 64'd0);
    expect_eq("lock_vs5_plus2", 64'(lk_at2), 64'd1);
    send_frame(100, 1'b0, 1'b0, 30);
    expect_eq("lock_hold_vs6", 64'(locked), 64'd1);

    send_frame(101, 1'b0, 1'b0, 30);
    send_frame(100, 1'b0, 1'b0, 30);
    expect_eq("h_total_101", 64'(h_total), 64'd101);
    expect_eq("unlock_on_change", 64'(locked), 64'd0);
    for (int f = 0; f < 3; f++) send_frame(100, 1'b0, 1'b0, 30);
    expect_eq("relock_pending", 64'(locked), 64'd0);
    send_frame(100, 1'b0, 1'b0, 30);
    expect_eq("relock", 64'({locked, h_total}), 64'({1'b1, 12'd100}));

    send_frame(100, 1'b0, 1'b0, 10);
    expect_eq("locked_before_reset", 64'({locked, pix_valid}), 64'({1'b1, 1'b1}));
    #1 reset = 1'b1;
    #1 check_zero("async_reset");
    vid_hs = 1'b0; vid_vs = 1'b0; vid_de = 1'b0; vid_d = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    h0 = '0;
    h1 = '0;
    send_frame(100, 1'b0, 1'b0, 30);
    expect_eq("post_reset_vs1", 64'({locked, h_total, v_total}), 64'd0);
    send_frame(100, 1'b0, 1'b0, 30);
    expect_eq("post_reset_vs2", 64'({h_total, h_active, v_total, v_active}), 64'(MEAS_OK));

    do_reset();
    tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 0, 0);
    for (int i = 0; i < 5000; i++) tick(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 0, 0);
    tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 0, 0);
    expect_eq("sat_meas", 64'({h_total, h_active, v_total, v_active}),
              64'({12'd4095, 12'd0, 12'd1, 12'd0}));
    expect_eq("sat_unlocked_1", 64'(locked), 64'd0);
    for (int i = 0; i < 4996; i++) tick(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 0, 0);
    tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 0, 0);
    expect_eq("sat_unlocked_2", 64'({locked, h_total}), 64'({1'b0, 12'd4095}));

`ifdef RX_TIMING_POL_AUTO_EN
    do_reset();
    for (int f = 0; f < 10; f++) send_frame(100, 1'b1, 1'b0, 30);
    expect_eq("pol_detect", 64'({hs_pol, vs_pol}), 64'({1'b1, 1'b1}));
    expect_eq("pol_meas", 64'({h_total, h_active, v_total, v_active}), 64'(MEAS_OK));
    expect_eq("pol_locked", 64'(locked), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
